// File: rtl/saph_raster_arbiter_pkg.sv
// Shared shape-type encodings and the held-shape record used by the raster arbiter.
// Vertices are opaque 32-bit words here; the rasterizer defines their internal layout.
package saph_raster_arbiter_pkg;

    localparam int SAPH_VTX_W = 32;

    localparam logic [1:0] SAPH_SHAPE_LINE = 2'd0;
    localparam logic [1:0] SAPH_SHAPE_TRI  = 2'd1;
    localparam logic [1:0] SAPH_SHAPE_RECT = 2'd2;
    localparam logic [1:0] SAPH_SHAPE_RSVD = 2'd3;

    typedef logic [SAPH_VTX_W-1:0] saph_vertex_t;

    typedef struct packed {
        logic [1:0]         shape_type;
        saph_vertex_t [3:0] vtx;
    } saph_shape_t;

endpackage

// File: rtl/saph_raster_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i (wrapping), as one-hot and index.
// Zero latency, no state; any_o is low when no request is set.
module saph_raster_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] k;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = '0;
        // Offset 1..N so the previous winner is examined last.
        for (int i = 1; i <= N; i++) begin
            k = IDX_W'((int'(ptr_i) + i) % N);
            if (!found && req_i[k]) begin
                gnt_o[k] = 1'b1;
                idx_o    = k;
                found    = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/saph_raster_arbiter.sv
// Round-robin share of one rasterizer across NUM_REQ producers; 1-cycle accept-to-trig, 1 shape/cycle,
// req_ready only while the holding slot is free or draining. SAPH_RASTER_ARB_STATS_EN adds per-requester counters.
module saph_raster_arbiter
    import saph_raster_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_trig,
    input  logic [NUM_REQ*2-1:0]            req_type,
    input  logic [NUM_REQ*4*SAPH_VTX_W-1:0] req_shape,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rast_trig,
    output logic [1:0]                      rast_type,
    output logic [4*SAPH_VTX_W-1:0]         rast_shape,
    input  logic                            rast_ready,
    output logic [ID_W-1:0]                 rast_id,
    output logic                            busy,
    output logic                            err_invalid,
    output logic [ID_W-1:0]                 err_id
`ifdef SAPH_RASTER_ARB_STATS_EN
    ,
    input  logic                            stat_clr,
    output logic [NUM_REQ*32-1:0]           stat_count
`endif
);

    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    saph_shape_t     hold_q, hold_d;
    logic            hold_vld_q, hold_vld_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            err_q, err_d;
    logic [ID_W-1:0] err_id_q, err_id_d;

    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_idx;
    logic                    gnt_any;
    logic                    slot_free;
    logic                    grant_ok;
    logic                    req_xfer;
    logic                    rast_xfer;
    logic [1:0]              sel_type;
    logic [4*SAPH_VTX_W-1:0] sel_vtx;

    saph_raster_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i (req_trig),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign slot_free = !hold_vld_q || rast_ready;
    // Gated by rst_n so no requester sees an accept while the arbiter is held in reset.
    assign grant_ok  = slot_free && !flush && rst_n;
    assign req_ready = grant_ok ? gnt : '0;
    assign req_xfer  = grant_ok && gnt_any;
    assign rast_xfer = hold_vld_q && rast_ready;

    assign sel_type = req_type[int'(gnt_idx)*2 +: 2];
    assign sel_vtx  = req_shape[int'(gnt_idx)*4*SAPH_VTX_W +: 4*SAPH_VTX_W];

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        err_d      = 1'b0;
        err_id_d   = err_id_q;
        if (flush) begin
            hold_vld_d = 1'b0;
            ptr_d      = PTR_RST;
        end else if (req_xfer) begin
            ptr_d = gnt_idx;
            if (sel_type != SAPH_SHAPE_RSVD) begin
                hold_d.shape_type = sel_type;
                hold_d.vtx        = sel_vtx;
                id_d              = gnt_idx;
                hold_vld_d        = 1'b1;
            end else begin
                // Reserved shapes are swallowed; the slot only empties if the rasterizer drained it.
                err_d    = 1'b1;
                err_id_d = gnt_idx;
                if (rast_xfer) begin
                    hold_vld_d = 1'b0;
                end
            end
        end else if (rast_xfer) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            id_q       <= '0;
            ptr_q      <= PTR_RST;
            err_q      <= 1'b0;
            err_id_q   <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            err_id_q   <= err_id_d;
        end
    end

    assign rast_trig   = hold_vld_q;
    assign busy        = hold_vld_q;
    assign rast_type   = hold_q.shape_type;
    assign rast_shape  = hold_q.vtx;
    assign rast_id     = id_q;
    assign err_invalid = err_q;
    assign err_id      = err_id_q;

`ifdef SAPH_RASTER_ARB_STATS_EN
    logic [31:0] stat_q [NUM_REQ];

    // Only valid shapes are ever held, so every rasterizer handshake is countable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (rast_xfer) begin
            stat_q[id_q] <= stat_q[id_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_count[g*32 +: 32] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_saph_raster_arbiter.sv
// Directed bench for saph_raster_arbiter with a rule-level reference model checked every cycle.
module tb_saph_raster_arbiter;
    import saph_raster_arbiter_pkg::*;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [3:0]   req_trig;
    logic [7:0]   req_type;
    logic [511:0] req_shape;
    logic [3:0]   req_ready;
    logic         rast_trig;
    logic [1:0]   rast_type;
    logic [127:0] rast_shape;
    logic         rast_ready;
    logic [1:0]   rast_id;
    logic         busy;
    logic         err_invalid;
    logic [1:0]   err_id;
`ifdef SAPH_RASTER_ARB_STATS_EN
    logic         stat_clr;
    logic [127:0] stat_count;
`endif

    saph_raster_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_trig    (req_trig),
        .req_type    (req_type),
        .req_shape   (req_shape),
        .req_ready   (req_ready),
        .rast_trig   (rast_trig),
        .rast_type   (rast_type),
        .rast_shape  (rast_shape),
        .rast_ready  (rast_ready),
        .rast_id     (rast_id),
        .busy        (busy),
        .err_invalid (err_invalid),
        .err_id      (err_id)
`ifdef SAPH_RASTER_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_count  (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producers: rem[i] shapes still to send; the current shape is held until accepted.
    int           rem [N];
    logic [1:0]   typ [N];
    logic [127:0] shp [N];
    int           seq;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_trig[i]           = (rem[i] > 0);
            req_type[i*2 +: 2]    = typ[i];
            req_shape[i*128 +: 128] = shp[i];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] r, input int p);
        for (int o = 1; o <= N; o++) begin
            if (r[(p + o) % N]) return (p + o) % N;
        end
        return -1;
    endfunction

    // Reference model state.
    int           m_vld, m_ptr, m_id, m_err, m_err_id;
    logic [1:0]   m_type;
    logic [127:0] m_shape;
    logic [31:0]  m_cnt [N];

    always @(posedge clk or negedge rst_n) begin
        int w, sf, xf, rx;
        if (!rst_n) begin
            m_vld = 0; m_ptr = N - 1; m_id = 0; m_err = 0; m_err_id = 0;
            m_type = '0; m_shape = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
        end else begin
            w  = winner(req_trig, m_ptr);
            sf = (m_vld == 0) || rast_ready;
            xf = (w >= 0) && sf && !flush;
            rx = m_vld && rast_ready;
`ifdef SAPH_RASTER_ARB_STATS_EN
            if (stat_clr) begin
                for (int i = 0; i < N; i++) m_cnt[i] = '0;
            end else if (rx) begin
                m_cnt[m_id] = m_cnt[m_id] + 32'd1;
            end
`endif
            m_err = 0;
            if (flush) begin
                m_vld = 0;
                m_ptr = N - 1;
            end else if (xf) begin
                m_ptr = w;
                if (typ[w] == 2'd3) begin
                    m_err = 1; m_err_id = w;
                    if (rx) m_vld = 0;
                end else begin
                    m_vld = 1; m_id = w; m_type = typ[w]; m_shape = shp[w];
                end
            end else if (rx) begin
                m_vld = 0;
            end
        end
    end

    logic [3:0] acc;
    logic [3:0] er;
    int         ew;
    int         gnt_log[$];
    int         id_log[$];
    int         acc_cnt [N];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 128'(req_ready), 128'd0);
            chk("rst_rast_trig", 128'(rast_trig), 128'd0);
            chk("rst_busy", 128'(busy), 128'd0);
            chk("rst_err_invalid", 128'(err_invalid), 128'd0);
            chk("rst_err_id", 128'(err_id), 128'd0);
            chk("rst_rast_id", 128'(rast_id), 128'd0);
            chk("rst_rast_type", 128'(rast_type), 128'd0);
            chk("rst_rast_shape", rast_shape, 128'd0);
            acc = '0;
        end else begin
            ew = winner(req_trig, m_ptr);
            er = '0;
            if (ew >= 0 && ((m_vld == 0) || rast_ready) && !flush) er[ew] = 1'b1;
            chk("req_ready", 128'(req_ready), 128'(er));
            chk("rast_trig", 128'(rast_trig), 128'(m_vld));
            chk("busy", 128'(busy), 128'(m_vld));
            if (m_vld != 0) begin
                chk("rast_type", 128'(rast_type), 128'(m_type));
                chk("rast_shape", rast_shape, m_shape);
                chk("rast_id", 128'(rast_id), 128'(m_id));
            end
            chk("err_invalid", 128'(err_invalid), 128'(m_err));
            chk("err_id", 128'(err_id), 128'(m_err_id));
`ifdef SAPH_RASTER_ARB_STATS_EN
            for (int i = 0; i < N; i++) chk("stat_count", 128'(stat_count[i*32 +: 32]), 128'(m_cnt[i]));
`endif
            acc = req_trig & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    gnt_log.push_back(i);
                    acc_cnt[i]++;
                end
            end
            if (rast_trig && rast_ready) id_log.push_back(int'(rast_id));
        end
    end

    // One clock: producers whose shape was accepted move on to a fresh shape.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                rem[i]--;
                seq++;
                shp[i] = {32'(i), 32'(seq), 32'hC0DE0000 | 32'(seq), ~32'(seq)};
            end
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    logic [127:0] saved;

    initial begin
        seq = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        rast_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 2; typ[i] = 2'(i % 3); shp[i] = {32'(i), 96'h5A5A};
            acc_cnt[i] = 0;
        end
`ifdef SAPH_RASTER_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        // 1: reset, then rotation 0,1,2,3,0 with ids trailing by one cycle
        repeat (3) @(posedge clk);
        #1;
        chk("t1_rst_ready", 128'(req_ready), 128'd0);
        chk("t1_rst_trig", 128'(rast_trig), 128'd0);
        rst_n = 1'b1;
        gnt_log.delete(); id_log.delete();
        repeat (9) step();
        chk("t1_ngnt", 128'(gnt_log.size()), 128'd8);
        if (gnt_log.size() >= 5) begin
            chk("t1_g0", 128'(gnt_log[0]), 128'd0);
            chk("t1_g1", 128'(gnt_log[1]), 128'd1);
            chk("t1_g2", 128'(gnt_log[2]), 128'd2);
            chk("t1_g3", 128'(gnt_log[3]), 128'd3);
            chk("t1_g4", 128'(gnt_log[4]), 128'd0);
        end
        chk("t1_nid", 128'(id_log.size()), 128'd8);
        if (id_log.size() >= 4) begin
            chk("t1_id0", 128'(id_log[0]), 128'd0);
            chk("t1_id3", 128'(id_log[3]), 128'd3);
        end

        // 2: backpressure holds the shape stable, then a bubble-free follow-on grant
        do_flush();
        rast_ready = 1'b0;
        rem[1] = 1; rem[2] = 1;
        saved = shp[1];
        gnt_log.delete();
        step();
        repeat (5) step();
        #1;
        chk("t2_trig", 128'(rast_trig), 128'd1);
        chk("t2_id", 128'(rast_id), 128'd1);
        chk("t2_shape", rast_shape, saved);
        chk("t2_ready_held", 128'(req_ready), 128'd0);
        rast_ready = 1'b1;
        #1;
        chk("t2_nobubble", 128'(req_ready), 128'b0100);
        step();
        #1;
        chk("t2_id_next", 128'(rast_id), 128'd2);
        step();
        chk("t2_order", 128'(gnt_log.size() == 2 && gnt_log[0] == 1 && gnt_log[1] == 2), 128'd1);

        // 3: reserved type is consumed with an error pulse, next grant rotates on
        do_flush();
        typ[2] = 2'd3; typ[3] = 2'd1;
        rem[2] = 1; rem[3] = 1;
        step();
        #1;
        chk("t3_err", 128'(err_invalid), 128'd1);
        chk("t3_err_id", 128'(err_id), 128'd2);
        chk("t3_no_trig", 128'(rast_trig), 128'd0);
        chk("t3_next_rdy", 128'(req_ready), 128'b1000);
        step();
        #1;
        chk("t3_err_off", 128'(err_invalid), 128'd0);
        chk("t3_id", 128'(rast_id), 128'd3);
        step();
        typ[2] = 2'd2;

        // 4: flush drops a stalled shape and restarts priority at requester 0
        rast_ready = 1'b0;
        rem[1] = 1;
        step();
        rem[0] = 1; rem[2] = 1;
        flush = 1'b1;
        #1;
        chk("t4_flush_rdy", 128'(req_ready), 128'd0);
        step();
        flush = 1'b0;
        #1;
        chk("t4_trig_off", 128'(rast_trig), 128'd0);
        chk("t4_first", 128'(req_ready), 128'b0001);
        rast_ready = 1'b1;
        repeat (3) step();

        // 5: lone requester streams one shape per cycle
        rem[3] = 100;
        acc_cnt[3] = 0;
        repeat (100) step();
        chk("t5_count", 128'(acc_cnt[3]), 128'd100);
        chk("t5_id", 128'(rast_id), 128'd3);
        step();

`ifdef SAPH_RASTER_ARB_STATS_EN
        // 6: counters see valid shapes only; clear beats a same-cycle increment
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        typ[0] = 2'd0;
        rem[0] = 10;
        repeat (12) step();
        typ[0] = 2'd3;
        rem[0] = 1;
        repeat (3) step();
        typ[0] = 2'd0;
        chk("t6_cnt0", 128'(stat_count[31:0]), 128'd10);
        rast_ready = 1'b0;
        rem[1] = 1;
        step();
        rast_ready = 1'b1;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        #1;
        chk("t6_clr1", 128'(stat_count[63:32]), 128'd0);
        chk("t6_clr0", 128'(stat_count[31:0]), 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
